// File: rtl/paint_pkg.sv
// Shared types and default dimensions for the pixel painter path.
// Used by the painters and by the scheduler that feeds them.
package paint_pkg;

    localparam int PAINT_X_SIZE   = 800;
    localparam int PAINT_Y_SIZE   = 480;
    localparam int PAINT_PIPE_LAT = 5;

    typedef logic signed [15:0] coord_t;
    typedef logic [15:0]        color_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic valid;
        logic sol;
        logic eol;
        logic eof;
    } side_t;

    typedef struct packed {
        color_t color;
        logic   sol;
        logic   eol;
        logic   eof;
    } pix_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head entry is read straight from the
// storage registers so the output only changes on a pop or a push.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
        if (wr_en) begin
            mem_d[wr_q] = din;
            wr_d        = bump(wr_q);
        end
        if (rd_en) begin
            rd_d = bump(rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/paint_scheduler.sv
// Sweeps one frame of coordinates into the non-stallable painter and
// re-times its colours into a flagged valid/ready pixel stream.
module paint_scheduler
    import paint_pkg::*;
#(
    parameter int X_SIZE     = PAINT_X_SIZE,
    parameter int Y_SIZE     = PAINT_Y_SIZE,
    parameter int PIPE_LAT   = PAINT_PIPE_LAT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   frame_start,
    output logic   busy,
    output logic   frame_done,
    output coord_t paint_x,
    output coord_t paint_y,
    output logic   paint_valid,
    input  color_t paint_color,
    output logic   out_valid,
    input  logic   out_ready,
    output color_t out_color,
    output logic   out_sol,
    output logic   out_eol,
    output logic   out_eof
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < PIPE_LAT + 2) begin : g_depth_check
        $error("paint_scheduler: FIFO_DEPTH must be at least PIPE_LAT+2");
    end

    logic [1:0]    state_q, state_d;
    coord_t        x_q, x_d, y_q, y_d;
    logic [CW-1:0] credit_q, credit_d;
    side_t         side_q [PIPE_LAT];
    side_t         side_d [PIPE_LAT];
    side_t         side_in;
    logic          issue, pop, push, last_x, last_y, drain_done;
    pix_t          fifo_din, fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;

    assign last_x = (x_q == coord_t'(X_SIZE - 1));
    assign last_y = (y_q == coord_t'(Y_SIZE - 1));
    assign issue  = (state_q == ST_ISSUE) && (credit_q != '0);
    assign pop    = out_valid && out_ready;
    assign push   = side_q[PIPE_LAT-1].valid;

    // Eof leaving with nothing else queued or in flight ends the frame.
    assign drain_done = pop && out_eof && (fifo_count == CW'(1))
                     && (credit_q == CW'(FIFO_DEPTH - 1));

    always_comb begin
        side_in.valid = issue;
        side_in.sol   = (x_q == '0);
        side_in.eol   = last_x;
        side_in.eof   = last_x && last_y;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        credit_d = credit_q + CW'(pop) - CW'(issue);
        side_d[0] = side_in;
        for (int i = 1; i < PIPE_LAT; i++) begin
            side_d[i] = side_q[i-1];
        end
        unique case (state_q)
            ST_IDLE:  if (frame_start) state_d = ST_ISSUE;
            ST_ISSUE: if (issue && last_x && last_y) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (issue) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            credit_q <= CW'(FIFO_DEPTH);
            side_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            credit_q <= credit_d;
            side_q   <= side_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(issue && credit_q == '0))
                else $error("paint_scheduler: credit underflow");
            assert (credit_q <= CW'(FIFO_DEPTH))
                else $error("paint_scheduler: credit overflow");
            assert (!(push && fifo_full))
                else $error("paint_scheduler: push into full FIFO");
        end
    end

    always_comb begin
        fifo_din.color = paint_color;
        fifo_din.sol   = side_q[PIPE_LAT-1].sol;
        fifo_din.eol   = side_q[PIPE_LAT-1].eol;
        fifo_din.eof   = side_q[PIPE_LAT-1].eof;
    end

    sync_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign frame_done  = (state_q == ST_DONE);
    assign paint_x     = x_q;
    assign paint_y     = y_q;
    assign paint_valid = issue;
    assign out_valid   = !fifo_empty;
    assign out_color   = fifo_dout.color;
    assign out_sol     = fifo_dout.sol;
    assign out_eol     = fifo_dout.eol;
    assign out_eof     = fifo_dout.eof;

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler on a 4x3 frame with a
// 5-stage painter model returning {y[7:0], x[7:0]}.
module tb_paint_scheduler;
    import paint_pkg::*;

    localparam int XS    = 4;
    localparam int YS    = 3;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int NPIX  = XS * YS;

    logic   clk = 1'b0;
    logic   rstn = 1'b0;
    logic   frame_start = 1'b0;
    logic   out_ready = 1'b0;
    logic   busy, frame_done, paint_valid;
    coord_t paint_x, paint_y;
    color_t paint_color, out_color;
    logic   out_valid, out_sol, out_eol, out_eof;
    color_t pipe [LAT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paint_scheduler #(
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .PIPE_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_valid (paint_valid),
        .paint_color (paint_color),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_color   (out_color),
        .out_sol     (out_sol),
        .out_eol     (out_eol),
        .out_eof     (out_eof)
    );

    always @(posedge clk) begin
        pipe[0] <= {paint_y[7:0], paint_x[7:0]};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign paint_color = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int b);
        logic [15:0] ec;
        ec = {8'(b / XS), 8'(b % XS)};
        chk({tag, " color"}, 32'(out_color), 32'(ec));
        chk({tag, " sol"}, 32'(out_sol), 32'(b % XS == 0));
        chk({tag, " eol"}, 32'(out_eol), 32'(b % XS == XS - 1));
        chk({tag, " eof"}, 32'(out_eof), 32'(b == NPIX - 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " paint_valid"}, 32'(paint_valid), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_sol"}, 32'(out_sol), 0);
        chk({tag, " out_eol"}, 32'(out_eol), 0);
        chk({tag, " out_eof"}, 32'(out_eof), 0);
        chk({tag, " paint_x"}, 32'(paint_x), 0);
        chk({tag, " paint_y"}, 32'(paint_y), 0);
        chk({tag, " out_color"}, 32'(out_color), 0);
    endtask

    // Cycle-exact frame with ready held high; frame_start is cycle 0.
    task automatic run_timed(input string tag);
        out_ready   = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            chk({tag, " busy"}, 32'(busy), 32'(c <= 18));
            chk({tag, " frame_done"}, 32'(frame_done), 32'(c == 19));
            chk({tag, " paint_valid"}, 32'(paint_valid), 32'(c <= 12));
            if (c <= 12) begin
                chk({tag, " paint_x"}, 32'(paint_x), 32'((c - 1) % XS));
                chk({tag, " paint_y"}, 32'(paint_y), 32'((c - 1) / XS));
            end
            chk({tag, " out_valid"}, 32'(out_valid), 32'(c >= 7 && c <= 18));
            if (c >= 7 && c <= 18) chk_beat({tag, " beat"}, c - 7);
            step();
        end
    endtask

    // Collects beats until frame_done under a ready mask, checking order,
    // stability under backpressure and a single frame_done.
    task automatic collect(input string tag, input logic [31:0] mask,
                           input bit poke, input int first_beat);
        int beat;
        int done_n;
        int cyc;
        int extra;
        logic hold;
        logic [18:0] held;
        beat   = first_beat;
        done_n = 0;
        cyc    = 0;
        hold   = 1'b0;
        held   = '0;
        while (done_n == 0 && cyc < 400) begin
            out_ready   = mask[cyc % 32];
            frame_start = poke && busy && (cyc % 5 == 2);
            if (hold) begin
                chk({tag, " hold valid"}, 32'(out_valid), 1);
                chk({tag, " hold data"},
                    32'({out_color, out_sol, out_eol, out_eof}), 32'(held));
            end
            if (frame_done) begin
                done_n++;
                chk({tag, " beats at done"}, beat, NPIX);
            end
            if (out_valid && out_ready) begin
                chk_beat({tag, " beat"}, beat);
                beat++;
            end
            hold = out_valid && !out_ready;
            held = {out_color, out_sol, out_eol, out_eof};
            step();
            cyc++;
        end
        frame_start = 1'b0;
        chk({tag, " frame_done count"}, done_n, 1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (frame_done || busy) extra++;
            step();
        end
        chk({tag, " quiet after done"}, extra, 0);
    endtask

    initial begin
        int n;

        rstn = 1'b0;
        repeat (3) step();
        chk_reset_vals("reset");
        rstn = 1'b1;
        step();
        chk("idle busy", 32'(busy), 0);

        run_timed("frame1");

        out_ready   = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            if (paint_valid) n++;
            step();
        end
        chk("stall issued", n, DEPTH);
        chk("stall paint_valid", 32'(paint_valid), 0);
        chk("stall hold x", 32'(paint_x), 0);
        chk("stall hold y", 32'(paint_y), 2);
        chk("stall out_valid", 32'(out_valid), 1);
        chk_beat("stall head", 0);
        out_ready = 1'b1;
        step();
        chk("resume paint_valid", 32'(paint_valid), 1);
        chk("resume x", 32'(paint_x), 0);
        chk("resume y", 32'(paint_y), 2);
        collect("stall", 32'hFFFF_FFFF, 1'b0, 1);

        out_ready   = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        collect("ragged", 32'hA5C3_96E1, 1'b1, 0);

        out_ready   = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (8) step();
        chk("pre-abort out_valid", 32'(out_valid), 1);
        rstn = 1'b0;
        step();
        chk_reset_vals("abort");
        rstn = 1'b1;
        step();
        chk("post-abort frame_done", 32'(frame_done), 0);
        chk("post-abort out_valid", 32'(out_valid), 0);
        run_timed("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
